fp_addsub_seq: RTL and testbench

- Parametrised, multi-cycle IEEE-754-style floating-point adder/subtractor.
- Successor to the single-precision combinational adder.
- Adds: configurable exponent/mantissa widths, add/sub op select, valid/ready handshakes on both sides, round-to-nearest-even, special-value handling and exception flags.
- Sits between an operand source and a result consumer on the datapath.

---
 rtl/fpadd_pkg.sv | 34 +++
 rtl/fp_lzc.sv | 29 ++
 rtl/fp_addsub_seq.sv | 272 +++++++++++++++++++++++++++
 tb/tb_fp_addsub_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpadd_pkg.sv
// Shared definitions for the sequential floating-point adder/subtractor.
//   state_t     : FSM encoding (IDLE, ALIGN, ADD, NORM, ROUND, OUT)
//   FLG_*       : bit positions inside the 4-bit flags word
//   canon_qnan  : canonical quiet NaN for a given exponent/fraction width,
//                 returned right-aligned in 64 bits (caller truncates).
package fpadd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ALIGN,
      ADD,
      NORM,
      ROUND,
      OUT
   } state_t;

   localparam int unsigned FLG_INV = 3;
   localparam int unsigned FLG_OVF = 2;
   localparam int unsigned FLG_UNF = 1;
   localparam int unsigned FLG_INX = 0;

   // Sign 0, exponent all ones, only the fraction MSB set.
   function automatic logic [63:0] canon_qnan(input int unsigned exp_w,
                                              input int unsigned man_w);
      logic [63:0] q;
      q = '0;
      for (int unsigned i = 0; i < exp_w; i++) begin
         q = q | (64'(1) << (man_w + i));
      end
      q = q | (64'(1) << (man_w - 1));
      return q;
   endfunction

endpackage

// File: rtl/fp_lzc.sv
// Parametrised leading-zero counter.
//   din      : input vector, MSB first
//   count    : number of zeros above the most significant set bit
//              (WIDTH when din is all zero)
//   all_zero : din has no set bit
module fp_lzc
   import fpadd_pkg::*;
#(
   parameter int unsigned WIDTH = 27,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] din,
   output logic [CNT_W-1:0] count,
   output logic             all_zero
);

   // Ascending scan: the highest set bit is the last one to write count.
   always_comb begin
      count = CNT_W'(WIDTH);
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (din[i]) begin
            count = CNT_W'(WIDTH - 1 - i);
         end
      end
   end

   assign all_zero = ~|din;

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754-style adder/subtractor, round-to-nearest-even,
// subnormals flushed to zero on input and output.
// Optional build macro: FPADD_FLAGS_EN (exception flags; tied to 0 if undefined).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : operand set (a, b, op) valid      in_ready  : block idle
//   op         : 0 = a+b, 1 = a-b
//   a, b       : operands {sign, exponent, fraction}
//   out_valid  : result/flags valid                out_ready : consumer accepts
//   result     : rounded result
//   flags      : {invalid, overflow, underflow, inexact}
module fp_addsub_seq
   import fpadd_pkg::*;
#(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   op,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   result,
   output logic [3:0]             flags
);

   localparam int unsigned W   = 1 + EXP_W + MAN_W;
   localparam int unsigned SW  = MAN_W + 4;          // hidden + fraction + G/R/S
   localparam int unsigned KW  = MAN_W + 2;          // kept significand + round carry
   localparam int unsigned LZW = $clog2(SW + 1);
   localparam int unsigned EW  = EXP_W + LZW + 1;    // signed working exponent

   localparam logic [W-1:0]          QNAN  = W'(canon_qnan(EXP_W, MAN_W));
   localparam logic signed [EW-1:0]  E_ONE = EW'(1);
   localparam logic signed [EW-1:0]  E_MAX = EW'((1 << EXP_W) - 1);

   state_t                 state;
   logic [W-1:0]           a_r, b_r;
   logic                   op_r;
   logic                   spec_r;
   logic [W-1:0]           spec_res_r;
   logic                   sign_r, zsign_r, sub_r, zero_r;
   logic signed [EW-1:0]   exp_r;
   logic [SW-1:0]          big_r, small_r, norm_r;
   logic [SW:0]            sum_r;

   // ---------------- ALIGN: unpack, classify, swap, align ----------------
   logic [EXP_W-1:0] ea, eb, e_l, e_s, diff;
   logic [MAN_W-1:0] fa, fb, fa_f, fb_f, f_l, f_s;
   logic             sa, b_sign, a_nan, b_nan, a_inf, b_inf, a_ge;
   logic [SW-1:0]    m_l, m_s, ones_sw, shifted, small_al;
   logic             lost, spec;
   logic [W-1:0]     spec_res;

   always_comb begin
      ea      = a_r[W-2:MAN_W];
      eb      = b_r[W-2:MAN_W];
      fa      = a_r[MAN_W-1:0];
      fb      = b_r[MAN_W-1:0];
      sa      = a_r[W-1];
      b_sign  = b_r[W-1] ^ op_r;
      a_nan   = (&ea) & (|fa);
      b_nan   = (&eb) & (|fb);
      a_inf   = (&ea) & ~(|fa);
      b_inf   = (&eb) & ~(|fb);
      // Subnormal inputs already carry exponent 0; dropping the fraction makes them zero.
      fa_f    = (ea == '0) ? '0 : fa;
      fb_f    = (eb == '0) ? '0 : fb;
      a_ge    = {ea, fa_f} >= {eb, fb_f};
      e_l     = a_ge ? ea : eb;
      e_s     = a_ge ? eb : ea;
      f_l     = a_ge ? fa_f : fb_f;
      f_s     = a_ge ? fb_f : fa_f;
      m_l     = (e_l == '0) ? '0 : {1'b1, f_l, 3'b000};
      m_s     = (e_s == '0) ? '0 : {1'b1, f_s, 3'b000};
      diff    = e_l - e_s;
      ones_sw = '1;
      shifted = m_s >> diff;
      lost    = |(m_s & ~(ones_sw << diff));
      if (32'(diff) >= 32'(SW - 1)) begin
         small_al = {{(SW-1){1'b0}}, |m_s};
      end else begin
         small_al = shifted | {{(SW-1){1'b0}}, lost};
      end

      spec     = 1'b0;
      spec_res = '0;
      if (a_nan || b_nan) begin
         spec     = 1'b1;
         spec_res = QNAN;
      end else if (a_inf && b_inf && (sa != b_sign)) begin
         spec     = 1'b1;
         spec_res = QNAN;
      end else if (a_inf) begin
         spec     = 1'b1;
         spec_res = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (b_inf) begin
         spec     = 1'b1;
         spec_res = {b_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end
   end

   // ---------------- NORM: leading-zero count ----------------
   logic [LZW-1:0] lz;
   logic           lz_zero;

   fp_lzc #(
      .WIDTH (SW),
      .CNT_W (LZW)
   ) u_lzc (
      .din      (sum_r[SW-1:0]),
      .count    (lz),
      .all_zero (lz_zero)
   );

   // ---------------- ROUND: nearest-even, renormalise, range check ----------------
   logic [KW-1:0]          keep, rounded;
   logic                   rnd_up;
   logic signed [EW-1:0]   exp_fin;
   logic [MAN_W-1:0]       frac_fin;
   logic                   ovf_c, unf_c;
   logic [W-1:0]           res_next;

   always_comb begin
      keep     = {1'b0, norm_r[SW-1:3]};
      rnd_up   = norm_r[2] & (norm_r[1] | norm_r[0] | norm_r[3]);
      rounded  = keep + KW'(rnd_up);
      exp_fin  = rounded[KW-1] ? (exp_r + E_ONE) : exp_r;
      frac_fin = rounded[KW-1] ? rounded[MAN_W:1] : rounded[MAN_W-1:0];
      ovf_c    = exp_fin >= E_MAX;
      unf_c    = exp_fin < E_ONE;
      if (spec_r) begin
         res_next = spec_res_r;
      end else if (zero_r) begin
         res_next = {zsign_r, {(W-1){1'b0}}};
      end else if (ovf_c) begin
         res_next = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (unf_c) begin
         res_next = {sign_r, {(W-1){1'b0}}};
      end else begin
         res_next = {sign_r, exp_fin[EXP_W-1:0], frac_fin};
      end
   end

   // ---------------- FSM and datapath registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         result     <= '0;
         a_r        <= '0;
         b_r        <= '0;
         op_r       <= 1'b0;
         spec_r     <= 1'b0;
         spec_res_r <= '0;
         sign_r     <= 1'b0;
         zsign_r    <= 1'b0;
         sub_r      <= 1'b0;
         zero_r     <= 1'b0;
         exp_r      <= '0;
         big_r      <= '0;
         small_r    <= '0;
         norm_r     <= '0;
         sum_r      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  a_r      <= a;
                  b_r      <= b;
                  op_r     <= op;
                  in_ready <= 1'b0;
                  state    <= ALIGN;
               end
            end
            ALIGN: begin
               spec_r     <= spec;
               spec_res_r <= spec_res;
               sign_r     <= a_ge ? sa : b_sign;
               // Exact zero is -0 only when both effective signs are negative.
               zsign_r    <= sa & b_sign;
               sub_r      <= sa ^ b_sign;
               exp_r      <= EW'(e_l);
               big_r      <= m_l;
               small_r    <= small_al;
               state      <= ADD;
            end
            ADD: begin
               sum_r <= sub_r ? ({1'b0, big_r} - {1'b0, small_r})
                              : ({1'b0, big_r} + {1'b0, small_r});
               state <= NORM;
            end
            NORM: begin
               if (sum_r[SW]) begin
                  norm_r <= {sum_r[SW:2], sum_r[1] | sum_r[0]};
                  exp_r  <= exp_r + E_ONE;
               end else begin
                  norm_r <= sum_r[SW-1:0] << lz;
                  exp_r  <= exp_r - EW'(lz);
               end
               zero_r <= lz_zero & ~sum_r[SW];
               state  <= ROUND;
            end
            ROUND: begin
               result    <= res_next;
               out_valid <= 1'b1;
               state     <= OUT;
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef FPADD_FLAGS_EN
   logic       spec_inv, spec_inv_r;
   logic [3:0] flags_r, flg_next;

   // Signalling NaN has the fraction MSB clear; inf-inf needs opposite effective signs.
   assign spec_inv = (a_nan & ~fa[MAN_W-1]) | (b_nan & ~fb[MAN_W-1]) |
                     (~a_nan & ~b_nan & a_inf & b_inf & (sa != b_sign));

   always_comb begin
      flg_next = '0;
      if (spec_r) begin
         flg_next[FLG_INV] = spec_inv_r;
      end else if (zero_r) begin
         flg_next = '0;
      end else if (ovf_c) begin
         flg_next[FLG_OVF] = 1'b1;
         flg_next[FLG_INX] = 1'b1;
      end else if (unf_c) begin
         flg_next[FLG_UNF] = 1'b1;
         flg_next[FLG_INX] = 1'b1;
      end else begin
         flg_next[FLG_INX] = |norm_r[2:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flags_r    <= '0;
         spec_inv_r <= 1'b0;
      end else begin
         if (state == ALIGN) begin
            spec_inv_r <= spec_inv;
         end
         if (state == ROUND) begin
            flags_r <= flg_next;
         end
      end
   end

   assign flags = flags_r;
`else
   assign flags = '0;
`endif

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Scoreboard bench for fp_addsub_seq: single-precision and half-precision instances.
module tb_fp_addsub_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

`ifdef FPADD_FLAGS_EN
   localparam logic [3:0] FLAG_MASK = 4'hF;
`else
   localparam logic [3:0] FLAG_MASK = 4'h0;
`endif

   logic        rst, in_valid, in_ready, op, out_valid, out_ready;
   logic [31:0] a, b, result;
   logic [3:0]  flags;

   logic        h_in_valid, h_in_ready, h_op, h_out_valid, h_out_ready;
   logic [15:0] h_a, h_b, h_result;
   logic [3:0]  h_flags;

   fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .flags(flags)
   );

   fp_addsub_seq #(.EXP_W(5), .MAN_W(10)) dut_h (
      .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready), .op(h_op),
      .a(h_a), .b(h_b), .out_valid(h_out_valid), .out_ready(h_out_ready),
      .result(h_result), .flags(h_flags)
   );

   typedef struct {
      logic [31:0] res;
      logic [3:0]  flg;
      string       name;
   } exp_t;

   exp_t sb_q[$];
   exp_t hq[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Single-precision monitor: checks every cycle out_valid is up (so a stalled
   // output is also checked for stability), pops on the transfer cycle.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got result %h, required no output", result);
         end else begin
            chk({sb_q[0].name, "_result"}, result, sb_q[0].res);
            chk({sb_q[0].name, "_flags"}, {28'h0, flags}, {28'h0, sb_q[0].flg});
            if (out_ready) void'(sb_q.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && h_out_valid) begin
         if (hq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL h_unexpected_output: got result %h, required no output", h_result);
         end else begin
            chk({hq[0].name, "_result"}, {16'h0, h_result}, hq[0].res);
            chk({hq[0].name, "_flags"}, {28'h0, h_flags}, {28'h0, hq[0].flg});
            if (h_out_ready) void'(hq.pop_front());
         end
      end
   end

   task automatic wait_ready(input string name);
      int n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL %s_ready_timeout: got in_ready 0, required 1", name);
      end
   endtask

   // Issue one single-precision operation; hold = cycles out_ready stays low in OUT.
   task automatic issue(input string name, input logic o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] er,
                        input logic [3:0] eflg, input int hold);
      int   cyc;
      logic busy;
      wait_ready(name);
      sb_q.push_back('{er, eflg & FLAG_MASK, name});
      in_valid = 1'b1;
      op = o;
      a = x;
      b = y;
      out_ready = (hold == 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      cyc = 1;
      busy = 1'b0;
      while (!out_valid && cyc < 20) begin
         if (in_ready) busy = 1'b1;
         @(posedge clk); #1;
         cyc++;
      end
      if (in_ready) busy = 1'b1;
      chk({name, "_latency"}, 32'(cyc), 32'd5);
      chk({name, "_in_ready_busy"}, {31'h0, busy}, 32'd0);
      if (hold > 0) begin
         repeat (hold) begin
            @(posedge clk); #1;
         end
         chk({name, "_held_valid"}, {31'h0, out_valid}, 32'd1);
         out_ready = 1'b1;
      end
      @(posedge clk); #1;
      chk({name, "_in_ready_after"}, {31'h0, in_ready}, 32'd1);
   endtask

   task automatic h_issue(input string name, input logic o, input logic [15:0] x,
                          input logic [15:0] y, input logic [15:0] er,
                          input logic [3:0] eflg);
      int n = 0;
      while (!h_in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      hq.push_back('{{16'h0, er}, eflg & FLAG_MASK, name});
      h_in_valid = 1'b1;
      h_op = o;
      h_a = x;
      h_b = y;
      @(posedge clk); #1;
      h_in_valid = 1'b0;
      n = 0;
      while (!h_out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, required finish within time limit");
      $fatal(1);
   end

   initial begin
      int   n;
      logic seen;
      rst = 1'b1;
      in_valid = 1'b0;
      op = 1'b0;
      a = '0;
      b = '0;
      out_ready = 1'b1;
      h_in_valid = 1'b0;
      h_op = 1'b0;
      h_a = '0;
      h_b = '0;
      h_out_ready = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
      end
      chk("reset_in_ready", {31'h0, in_ready}, 32'd1);
      chk("reset_out_valid", {31'h0, out_valid}, 32'd0);
      chk("reset_result", result, 32'h0);
      chk("reset_flags", {28'h0, flags}, 32'h0);
      rst = 1'b0;

      // Flags: {invalid, overflow, underflow, inexact}
      // Sum 0x1A91E97 >> 1: G=1, R=S=0 and odd LSB -> rounds up.
      issue("add_tie_odd",  1'b0, 32'h3F576AA4, 32'h3F51B3F3, 32'h3FD48F4C, 4'b0001, 0);
      issue("add_held",     1'b0, 32'h3E43636F, 32'h3F7FA62F, 32'h3F983F85, 4'b0001, 3);
      issue("sub_equal",    1'b1, 32'h3F800000, 32'h3F800000, 32'h00000000, 4'b0000, 0);
      issue("inf_minus_inf",1'b0, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000, 0);
      issue("overflow",     1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 4'b0101, 0);
      issue("tie_even",     1'b0, 32'h3F800000, 32'h33800000, 32'h3F800000, 4'b0001, 0);
      issue("above_half",   1'b0, 32'h3F800000, 32'h33C00000, 32'h3F800001, 4'b0001, 0);
      issue("round_carry",  1'b0, 32'h3F7FFFFF, 32'h33000000, 32'h3F800000, 4'b0001, 0);
      issue("shift_26",     1'b0, 32'h3F800000, 32'h32800000, 32'h3F800000, 4'b0001, 0);
      issue("shift_huge",   1'b0, 32'h3F800000, 32'h00800000, 32'h3F800000, 4'b0001, 0);
      issue("snan",         1'b0, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000, 0);
      issue("qnan",         1'b0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000, 0);
      issue("fin_minus_inf",1'b1, 32'h3F800000, 32'h7F800000, 32'hFF800000, 4'b0000, 0);
      issue("negz_plus_negz",1'b0,32'h80000000, 32'h80000000, 32'h80000000, 4'b0000, 0);
      issue("negz_minus_z", 1'b1, 32'h80000000, 32'h00000000, 32'h80000000, 4'b0000, 0);
      issue("negz_plus_z",  1'b0, 32'h80000000, 32'h00000000, 32'h00000000, 4'b0000, 0);
      issue("cancel",       1'b1, 32'h3FC00000, 32'h3F800000, 32'h3F000000, 4'b0000, 0);
      issue("swap_neg",     1'b1, 32'h3F800000, 32'h40000000, 32'hBF800000, 4'b0000, 0);
      issue("underflow",    1'b1, 32'h00C00000, 32'h00800000, 32'h00000000, 4'b0011, 0);
      issue("subnorm_in",   1'b0, 32'h00000001, 32'h3F800000, 32'h3F800000, 4'b0000, 0);

      // Reset while the operation sits in ADD: it must vanish without output.
      wait_ready("rst_mid");
      in_valid = 1'b1;
      op = 1'b0;
      a = 32'h3F800000;
      b = 32'h3F800000;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_in_ready", {31'h0, in_ready}, 32'd1);
      chk("rst_mid_out_valid", {31'h0, out_valid}, 32'd0);
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      chk("rst_mid_no_output", {31'h0, seen}, 32'd0);
      issue("after_reset",  1'b0, 32'h3F800000, 32'h3F800000, 32'h40000000, 4'b0000, 0);

      h_issue("half_add",      1'b0, 16'h3C00, 16'h3C00, 16'h4000, 4'b0000);
      h_issue("half_sub",      1'b1, 16'h3C00, 16'h3C00, 16'h0000, 4'b0000);
      h_issue("half_overflow", 1'b0, 16'h7BFF, 16'h7BFF, 16'h7C00, 4'b0101);

      n = 0;
      while ((sb_q.size() != 0 || hq.size() != 0) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("scoreboard_drained", 32'(sb_q.size() + hq.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
